// File: rtl/psum_collector_if.sv
// Psum-in / ofmap-out bundle for psum_collector: per-lane psum stream from the
// PE array plus the valid/ready drain port.
interface psum_collector_if #(
  parameter int G_ARRAY_WIDTH = 4,
  parameter int D             = 16
);
  logic [0:G_ARRAY_WIDTH-1]        psum_vld_i;
  logic [0:G_ARRAY_WIDTH-1][D-1:0] psum_i;
  logic                            ofmap_vld_o;
  logic                            ofmap_rdy_i;
  logic [D-1:0]                    ofmap_o;

  modport slave  (input psum_vld_i, psum_i, ofmap_rdy_i, output ofmap_vld_o, ofmap_o);
  modport master (output psum_vld_i, psum_i, ofmap_rdy_i, input ofmap_vld_o, ofmap_o);
endinterface

// File: rtl/psum_collector.sv
// Multi-pass saturating psum accumulator with lane-major valid/ready drain.
// Optional macro PSUM_COLLECTOR_RELU_EN clamps negative drained values to 0.
module psum_collector_lane #(
  parameter int D   = 16,
  parameter int OFW = 24,
  parameter int KW  = 5,
  parameter int EW  = 5
)(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr,
  input  logic          accum,
  input  logic          first,
  input  logic          pass_end,
  input  logic          vld,
  input  logic [D-1:0]  psum,
  input  logic [EW-1:0] rd_idx,
  output logic          full_nxt,
  output logic          sat,
  output logic          drop,
  output logic [D-1:0]  rd_data
);
  logic [D-1:0]  acc [OFW];
  logic [KW-1:0] k;
  logic [EW-1:0] wi;
  logic          take;
  logic [D:0]    sum;
  logic          ovr;
  logic [D-1:0]  wdata;

  always_comb begin
    take     = accum && vld && (k != KW'(OFW));
    drop     = vld && !take;
    wi       = (k == KW'(OFW)) ? '0 : EW'(k);
    sum      = {acc[wi][D-1], acc[wi]} + {psum[D-1], psum};
    // Sign disagreement between the two top bits means the true sum left D-bit range
    ovr      = sum[D] ^ sum[D-1];
    sat      = take && !first && ovr;
    full_nxt = (k + KW'(take)) == KW'(OFW);
    if (first)    wdata = psum;
    else if (ovr) wdata = sum[D] ? {1'b1, {(D-1){1'b0}}} : {1'b0, {(D-1){1'b1}}};
    else          wdata = sum[D-1:0];
    rd_data  = acc[rd_idx];
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                 k <= '0;
    else if (clr || pass_end)   k <= '0;
    else if (take)              k <= k + KW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (take) acc[wi] <= wdata;
  end
endmodule

module psum_collector #(
  parameter int G_ARRAY_WIDTH = 4,
  parameter int G_TOP_BITS    = 2,
  parameter int G_BOT_BITS    = 14,
  parameter int G_OFMAP_WIDTH = 24
)(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [3:0] num_pass_i,
  psum_collector_if.slave bus,
  output logic       busy_o,
  output logic       done_o,
  output logic       ovf_o,
  output logic       err_o
);
  localparam int D   = G_TOP_BITS + G_BOT_BITS;
  localparam int W   = G_ARRAY_WIDTH;
  localparam int OFW = G_OFMAP_WIDTH;
  localparam int KW  = $clog2(OFW + 1);
  localparam int EW  = (OFW > 1) ? $clog2(OFW) : 1;
  localparam int LW  = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;
  state_t state_q, state_d;

  logic [3:0]            pass_q, num_pass_q;
  logic [LW-1:0]         rd_lane, nl;
  logic [EW-1:0]         rd_elem, ne;
  logic                  ofmap_vld;
  logic [D-1:0]          ofmap;
  logic                  clr, accum, first, pass_end, last_pass, last_elem, hs;
  logic [W-1:0]          full_nxt, sat, drop;
  logic [W-1:0][D-1:0]   lane_rd;

  function automatic logic [D-1:0] post(input logic [D-1:0] v);
`ifdef PSUM_COLLECTOR_RELU_EN
    return v[D-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  for (genvar c = 0; c < W; c++) begin : g_lane
    psum_collector_lane #(.D(D), .OFW(OFW), .KW(KW), .EW(EW)) u_lane (
      .clk_i, .rst_i, .clr, .accum, .first, .pass_end,
      .vld(bus.psum_vld_i[c]), .psum(bus.psum_i[c]), .rd_idx(ne),
      .full_nxt(full_nxt[c]), .sat(sat[c]), .drop(drop[c]), .rd_data(lane_rd[c]));
  end

  always_comb begin
    clr       = (state_q == IDLE) && start_i;
    accum     = (state_q == ACCUM);
    first     = (pass_q == 4'd0);
    pass_end  = accum && (&full_nxt);
    last_pass = (pass_q == num_pass_q - 4'd1);
    last_elem = (rd_lane == LW'(W - 1)) && (rd_elem == EW'(OFW - 1));
    hs        = ofmap_vld && bus.ofmap_rdy_i;
    // Read address runs one element ahead so the registered output can refill on each handshake
    nl = rd_lane;
    ne = rd_elem;
    if (ofmap_vld) begin
      if (rd_elem == EW'(OFW - 1)) begin
        nl = rd_lane + LW'(1);
        ne = '0;
      end else begin
        ne = rd_elem + EW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = ACCUM;
      ACCUM:   if (pass_end && last_pass) state_d = DRAIN;
      DRAIN:   if (hs && last_elem) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pass_q     <= '0;
      num_pass_q <= '0;
      rd_lane    <= '0;
      rd_elem    <= '0;
      ofmap_vld  <= 1'b0;
      ofmap      <= '0;
      done_o     <= 1'b0;
      ovf_o      <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (clr) begin
        num_pass_q <= (num_pass_i == 4'd0) ? 4'd1 : num_pass_i;
        pass_q     <= '0;
        rd_lane    <= '0;
        rd_elem    <= '0;
        ovf_o      <= 1'b0;
        err_o      <= |drop;
      end else begin
        err_o <= err_o | (|drop);
        ovf_o <= ovf_o | (|sat);
      end
      if (pass_end) pass_q <= pass_q + 4'd1;
      if (state_q == DRAIN) begin
        if (!ofmap_vld) begin
          ofmap     <= post(lane_rd[nl]);
          ofmap_vld <= 1'b1;
        end else if (hs) begin
          if (last_elem) begin
            ofmap_vld <= 1'b0;
            done_o    <= 1'b1;
          end else begin
            ofmap   <= post(lane_rd[nl]);
            rd_lane <= nl;
            rd_elem <= ne;
          end
        end
      end
    end
  end

  assign busy_o          = (state_q != IDLE);
  assign bus.ofmap_vld_o = ofmap_vld;
  assign bus.ofmap_o     = ofmap;
endmodule

// File: tb/tb_psum_collector.sv
// Directed bench for psum_collector: vector table of uniform-value jobs plus
// ordered-drain, stall, drop-error and mid-job reset sequences.
module tb_psum_collector;
  localparam int W = 4, OFW = 24, D = 16, N = W * OFW;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] num_pass = '0;
  logic       busy, done, ovf, err;
  int         n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  psum_collector_if #(.G_ARRAY_WIDTH(W), .D(D)) bus();

  psum_collector #(.G_ARRAY_WIDTH(W), .G_TOP_BITS(2), .G_BOT_BITS(14), .G_OFMAP_WIDTH(OFW)) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .num_pass_i(num_pass), .bus(bus),
    .busy_o(busy), .done_o(done), .ovf_o(ovf), .err_o(err));

  typedef struct {
    logic [3:0]   np;
    logic [D-1:0] p0, p1, p2;
    logic [D-1:0] exp;
    logic         ovf;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_job(input logic [3:0] np);
    start = 1'b1; num_pass = np;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_start", busy, 1);
    chk("flags_clear", {ovf, err}, 0);
  endtask

  task automatic feed_pass(input bit pat, input logic [D-1:0] val);
    for (int k = 0; k < OFW; k++) begin
      for (int c = 0; c < W; c++) begin
        bus.psum_vld_i[c] = 1'b1;
        bus.psum_i[c]     = pat ? val + D'(c * OFW + k) : val;
      end
      @(posedge clk); #1;
    end
    bus.psum_vld_i = '0;
  endtask

  task automatic drain(input bit pat, input logic [D-1:0] val, input bit stall);
    int idx = 0, cyc = 0, last_hs = 0;
    bit stalled = 0;
    logic [D-1:0] held = '0, exp;
    while (idx < N && cyc < 4 * N) begin
      if (stalled) begin
        chk("stall_vld", bus.ofmap_vld_o, 1);
        chk("stall_hold", bus.ofmap_o, held);
      end
      bus.ofmap_rdy_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = 0;
      if (bus.ofmap_vld_o) begin
        if (bus.ofmap_rdy_i) begin
          exp = pat ? val + D'(idx) : val;
          chk("drain_data", bus.ofmap_o, exp);
          if (!stall && idx > 0) chk("drain_gap", cyc - last_hs, 1);
          last_hs = cyc;
          idx++;
        end else begin
          stalled = 1;
          held = bus.ofmap_o;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.ofmap_rdy_i = 1'b1;
    if (idx < N) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: got %0d elements expected %0d", idx, N);
    end
    chk("done_pulse", done, 1);
    chk("vld_after", bus.ofmap_vld_o, 0);
    chk("busy_after", busy, 0);
    @(posedge clk); #1;
    chk("done_clear", done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.psum_vld_i  = '0;
    bus.psum_i      = '0;
    bus.ofmap_rdy_i = 1'b1;

    vecs[0] = '{np: 4'd3, p0: 16'h0100, p1: 16'h0100, p2: 16'h0100, exp: 16'h0300, ovf: 1'b0};
    vecs[1] = '{np: 4'd2, p0: 16'h7000, p1: 16'h7000, p2: 16'h0000, exp: 16'h7FFF, ovf: 1'b1};
`ifdef PSUM_COLLECTOR_RELU_EN
    vecs[2] = '{np: 4'd2, p0: 16'h9000, p1: 16'h9000, p2: 16'h0000, exp: 16'h0000, ovf: 1'b1};
    vecs[5] = '{np: 4'd2, p0: 16'hC000, p1: 16'hC000, p2: 16'h0000, exp: 16'h0000, ovf: 1'b0};
`else
    vecs[2] = '{np: 4'd2, p0: 16'h9000, p1: 16'h9000, p2: 16'h0000, exp: 16'h8000, ovf: 1'b1};
    vecs[5] = '{np: 4'd2, p0: 16'hC000, p1: 16'hC000, p2: 16'h0000, exp: 16'h8000, ovf: 1'b0};
`endif
    vecs[3] = '{np: 4'd0, p0: 16'h1234, p1: 16'h0000, p2: 16'h0000, exp: 16'h1234, ovf: 1'b0};
    vecs[4] = '{np: 4'd2, p0: 16'h4000, p1: 16'hC000, p2: 16'h0000, exp: 16'h0000, ovf: 1'b0};
    vecs[6] = '{np: 4'd2, p0: 16'h3FFF, p1: 16'h4000, p2: 16'h0000, exp: 16'h7FFF, ovf: 1'b0};

    repeat (3) @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_flags", {ovf, err}, 0);
    chk("rst_vld", bus.ofmap_vld_o, 0);
    chk("rst_ofmap", bus.ofmap_o, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Ordered single-pass job, element value = lane*24 + index
    start_job(4'd1);
    feed_pass(1, 16'h0000);
    drain(1, 16'h0000, 0);
    chk("pat_ovf", ovf, 0);
    chk("pat_err", err, 0);

    foreach (vecs[i]) begin
      start_job(vecs[i].np);
      feed_pass(0, vecs[i].p0);
      if (vecs[i].np >= 4'd2) feed_pass(0, vecs[i].p1);
      if (vecs[i].np >= 4'd3) feed_pass(0, vecs[i].p2);
      drain(0, vecs[i].exp, 0);
      chk("vec_ovf", ovf, vecs[i].ovf);
      chk("vec_err", err, 0);
    end

    // Backpressure during drain
    start_job(4'd1);
    feed_pass(1, 16'h0100);
    drain(1, 16'h0100, 1);

    // Psum valid while idle is dropped and flagged
    bus.psum_vld_i = '1;
    bus.psum_i     = '{default: 16'h1111};
    @(posedge clk); #1;
    bus.psum_vld_i = '0;
    chk("idle_drop_err", err, 1);

    // 25th psum on lane 2 is dropped while lane 3 finishes the pass
    start_job(4'd1);
    for (int k = 0; k < OFW; k++) begin
      for (int c = 0; c < W; c++) begin
        bus.psum_vld_i[c] = (c < 3) || (k < OFW - 1);
        bus.psum_i[c]     = 16'h0200 + D'(c * OFW + k);
      end
      @(posedge clk); #1;
    end
    bus.psum_vld_i    = '0;
    bus.psum_vld_i[2] = 1'b1;
    bus.psum_i[2]     = 16'h5555;
    bus.psum_vld_i[3] = 1'b1;
    bus.psum_i[3]     = 16'h0200 + D'(3 * OFW + OFW - 1);
    @(posedge clk); #1;
    bus.psum_vld_i = '0;
    chk("lane_over_err", err, 1);
    drain(1, 16'h0200, 0);
    chk("lane_over_err_sticky", err, 1);

    // Reset in the middle of a saturating second pass
    start_job(4'd2);
    feed_pass(0, 16'h7000);
    bus.psum_vld_i = '1;
    bus.psum_i     = '{default: 16'h7000};
    repeat (3) @(posedge clk);
    #1;
    bus.psum_vld_i = '0;
    chk("mid_ovf", ovf, 1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_flags", {ovf, err, done}, 0);
    chk("mid_rst_vld", bus.ofmap_vld_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_job(4'd1);
    feed_pass(1, 16'h0010);
    drain(1, 16'h0010, 0);
    chk("post_rst_flags", {ovf, err}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/psum_collector.md
PSUM_COLLECTOR -- requirements
Module: psum_collector

Interface
REQ-001 SHALL have parameter G_ARRAY_WIDTH, 4: number of PE-array columns (psum lanes).
REQ-002 SHALL have parameter G_TOP_BITS, 2: integer bits of the signed fixed-point psum.
REQ-003 SHALL have parameter G_BOT_BITS, 14: fraction bits; D = G_TOP_BITS+G_BOT_BITS.
REQ-004 SHALL have parameter G_OFMAP_WIDTH, 24: psums per column per pass (ofmap row length).
REQ-005 SHALL have port clk_i, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_i, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port start_i, input, 1: one-cycle job start pulse.
REQ-008 SHALL have port num_pass_i, input, 4: accumulation passes per job, sampled on start_i; 0 is treated as 1.
REQ-009 SHALL have port psum_vld_i, input, [0:G_ARRAY_WIDTH-1]: per-lane psum valid from the array's bottom edge.
REQ-010 SHALL have port psum_i, input, [0:G_ARRAY_WIDTH-1][D-1:0]: per-lane psum data.
REQ-011 SHALL have port ofmap_vld_o, output, 1: drain data valid.
REQ-012 SHALL have port ofmap_rdy_i, input, 1: downstream ready.
REQ-013 SHALL have port ofmap_o, output, D: drained ofmap element.
REQ-014 SHALL have port busy_o, output, 1: high in ACCUM or DRAIN.
REQ-015 SHALL have port done_o, output, 1: one-cycle job-complete pulse.
REQ-016 SHALL have ports ovf_o and err_o, outputs, 1 each: sticky saturation flag and sticky dropped-psum flag.

Function
REQ-017 SHALL implement FSM IDLE -> ACCUM on start_i; ACCUM -> DRAIN after the last pass completes; DRAIN -> IDLE after the final handshake.
REQ-018 SHALL ignore start_i while busy_o=1; start_i in IDLE clears ovf_o, err_o, all lane counters and the pass counter.
REQ-019 SHALL hold G_ARRAY_WIDTH x G_OFMAP_WIDTH accumulator entries, each with a per-lane write index k.
REQ-020 SHALL, in ACCUM on psum_vld_i[c], write acc[c][k] = psum_i[c] on pass 0, else sat(acc[c][k] + psum_i[c]), then increment k; result visible the next cycle.
REQ-021 SHALL accept valid psums on all lanes in the same cycle with no stall.
REQ-022 SHALL saturate signed sums to +(2^(D-1)-1) / -(2^(D-1)) and set ovf_o on any saturation.
REQ-023 SHALL end a pass when every lane's k equals G_OFMAP_WIDTH; then k resets to 0 and the pass counter increments.
REQ-024 SHALL drop a psum_vld_i arriving outside ACCUM, or on a lane whose k already equals G_OFMAP_WIDTH, and set err_o; the buffer is not modified.
REQ-025 SHALL drain in lane-major order: lane 0 elements 0..G_OFMAP_WIDTH-1, then lane 1, and so on.
REQ-026 SHALL assert ofmap_vld_o in the first cycle after entering DRAIN, with ofmap_o registered.
REQ-027 SHALL, while ofmap_vld_o=1 and ofmap_rdy_i=0, hold ofmap_o stable and keep ofmap_vld_o high.
REQ-028 SHALL advance one element per cycle while ofmap_rdy_i stays high (full throughput).
REQ-029 SHALL pulse done_o in the cycle after the final handshake, when the FSM is back in IDLE with ofmap_vld_o=0.

Reset
REQ-030 SHALL, on rst_i=0 at any time including mid-job, force IDLE and drive ofmap_vld_o, ofmap_o, busy_o, done_o, ovf_o and err_o to 0, and clear all counters.
REQ-031 SHALL NOT reset accumulator contents; they are don't-care until overwritten on pass 0.

Configuration
REQ-032 SHALL support macro PSUM_COLLECTOR_RELU_EN: when defined, negative drained values are output as 0; when undefined, drained values pass through unchanged. Accumulation is unaffected in both cases.

Verification
REQ-033 SHALL cover this case: W=4, OFW=24, num_pass=1, lane c element k = c*24+k (Q2.14 raw), rdy tied 1 -> 96 outputs in order, consecutive cycles, then one done_o pulse.
REQ-034 SHALL cover this case: num_pass=3, every psum=0x0100 -> every output 0x0300, ovf_o=0.
REQ-035 SHALL cover this case: num_pass=2, psums 0x7000 then 0x7000 -> output 0x7FFF and ovf_o=1; same test with -0x7000 twice -> output 0x8000 (0 with RELU_EN).
REQ-036 SHALL cover this case: rdy toggled 1/0 pseudo-randomly during drain -> no element lost or duplicated, ofmap_o stable while stalled.
REQ-037 SHALL cover this case: psum_vld_i in IDLE, or a 25th psum on lane 2 -> err_o=1 and buffer unchanged.
REQ-038 SHALL cover this case: rst_i low mid-ACCUM, then a new start -> clean job output, flags 0.
